// File: rtl/sin_frame_dispatcher_pkg.sv
// Shared definitions for the sine-frame dispatcher: channel/table geometry,
// dispatcher state encoding and a small width helper.
package sin_frame_dispatcher_pkg;

    localparam int NUM_OF_MODULES = 9;
    localparam int NUM_OF_PHASES  = 3;
    localparam int MODULE_OFFSET  = 0;
    localparam int PHASE_OFFSET   = 85;
    localparam int TABLE_DEPTH    = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_FETCH     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SHOOT     = 3'd5,
        ST_WAIT_TICK = 3'd6
    } disp_state_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sin_frame_dispatcher_timer.sv
// Step timer: loaded with TICKS-1 at frame start, counts down to zero and
// holds there; expired is high while the count sits at zero.
module sin_frame_dispatcher_timer
    import sin_frame_dispatcher_pkg::*;
#(
    parameter int TICKS = 48000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int CNT_W = idx_width(TICKS);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter with reload; parks at zero until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == '0);

endmodule

// File: rtl/sin_frame_dispatcher.sv
// Sine-frame dispatcher: walks the sine table once per step, hands one byte
// per (module, phase) to the matching UART TX, then pulses shoot once every
// byte of the frame has left the wire.
module sin_frame_dispatcher #(
    parameter int NUM_OF_MODULES = sin_frame_dispatcher_pkg::NUM_OF_MODULES,
    parameter int NUM_OF_PHASES  = sin_frame_dispatcher_pkg::NUM_OF_PHASES,
    parameter int MODULE_OFFSET  = sin_frame_dispatcher_pkg::MODULE_OFFSET,
    parameter int PHASE_OFFSET   = sin_frame_dispatcher_pkg::PHASE_OFFSET,
    parameter int TABLE_DEPTH    = sin_frame_dispatcher_pkg::TABLE_DEPTH,
    parameter int STEP_TICKS     = 48000,
    parameter int SHOOT_WIDTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic [15:0]                 ram_addr,
    input  logic [7:0]                  ram_data,
    output logic [NUM_OF_MODULES-1:0]   start_tx,
    output logic [8*NUM_OF_MODULES-1:0] data_to_tx,
    input  logic [NUM_OF_MODULES-1:0]   tx_busy,
    output logic                        shoot,
    output logic                        frame_done,
    output logic [15:0]                 base_index,
    output logic                        busy
);
    import sin_frame_dispatcher_pkg::*;

    localparam int IDX_W = idx_width(TABLE_DEPTH);
    localparam int MOD_W = idx_width(NUM_OF_MODULES);
    localparam int PH_W  = idx_width(NUM_OF_PHASES);
    localparam int SH_W  = idx_width(SHOOT_WIDTH);

    // Offsets reduced into table-index width; the wrap is free truncation.
    localparam logic [IDX_W-1:0] MOD_STEP   = IDX_W'(MODULE_OFFSET % TABLE_DEPTH);
    localparam logic [IDX_W-1:0] PH_STEP    = IDX_W'(PHASE_OFFSET % TABLE_DEPTH);
    localparam logic [MOD_W-1:0] MOD_LAST   = MOD_W'(NUM_OF_MODULES - 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(NUM_OF_PHASES - 1);
    localparam logic [SH_W-1:0]  SHOOT_LAST = SH_W'(SHOOT_WIDTH - 1);
    localparam logic [1:0]       GUARD_LAST = 2'd2;
    localparam logic [NUM_OF_MODULES-1:0] ONE_HOT0 = NUM_OF_MODULES'(1'b1);

    disp_state_e state_r, state_s;
    logic [MOD_W-1:0]  mod_r, mod_s;
    logic [PH_W-1:0]   ph_r, ph_s;
    // ph_acc holds base + j*PHASE_OFFSET; addr_acc adds i*MODULE_OFFSET on top.
    logic [IDX_W-1:0]  ph_acc_r, ph_acc_s;
    logic [IDX_W-1:0]  addr_acc_r, addr_acc_s;
    logic [IDX_W-1:0]  base_r, base_s;
    logic [1:0]        drain_cnt_r, drain_cnt_s;
    logic [SH_W-1:0]   shoot_cnt_r, shoot_cnt_s;
    logic [NUM_OF_MODULES-1:0]      start_tx_r, start_tx_s;
    logic [NUM_OF_MODULES-1:0][7:0] data_r;
    logic              shoot_r, frame_done_r, busy_r;
    logic              capture_s;
    logic              timer_load_s;
    logic              step_expired_s;

    sin_frame_dispatcher_timer #(
        .TICKS (STEP_TICKS)
    ) u_step_timer (
        .clk     (clk),
        .rst_n   (reset),
        .load    (timer_load_s),
        .expired (step_expired_s)
    );

    // Next-state, index walk and strobe generation.
    always_comb begin
        state_s      = state_r;
        mod_s        = mod_r;
        ph_s         = ph_r;
        ph_acc_s     = ph_acc_r;
        addr_acc_s   = addr_acc_r;
        base_s       = base_r;
        drain_cnt_s  = drain_cnt_r;
        shoot_cnt_s  = shoot_cnt_r;
        start_tx_s   = '0;
        capture_s    = 1'b0;
        timer_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    timer_load_s = 1'b1;
                    mod_s        = '0;
                    ph_s         = '0;
                    ph_acc_s     = base_r;
                    addr_acc_s   = base_r;
                    state_s      = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                capture_s = 1'b1;
                state_s   = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!tx_busy[mod_r]) begin
                    start_tx_s = ONE_HOT0 << mod_r;
                    if (mod_r == MOD_LAST) begin
                        mod_s = '0;
                        if (ph_r == PH_LAST) begin
                            ph_s        = '0;
                            drain_cnt_s = 2'd0;
                            state_s     = ST_DRAIN;
                        end else begin
                            ph_s       = ph_r + PH_W'(1);
                            ph_acc_s   = ph_acc_r + PH_STEP;
                            addr_acc_s = ph_acc_r + PH_STEP;
                            state_s    = ST_ADDR;
                        end
                    end else begin
                        mod_s      = mod_r + MOD_W'(1);
                        addr_acc_s = addr_acc_r + MOD_STEP;
                        state_s    = ST_ADDR;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // Guard cycles let the last UART raise tx_busy before we look.
                if (drain_cnt_r != GUARD_LAST) begin
                    drain_cnt_s = drain_cnt_r + 2'd1;
                end else if (tx_busy == '0) begin
                    shoot_cnt_s = '0;
                    state_s     = ST_SHOOT;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_SHOOT: begin
                if (shoot_cnt_r == SHOOT_LAST) begin
                    base_s  = base_r + IDX_W'(1);
                    state_s = ST_WAIT_TICK;
                end else begin
                    shoot_cnt_s = shoot_cnt_r + SH_W'(1);
                end
            end
            ST_WAIT_TICK: begin
                if (step_expired_s) begin
                    if (enable) begin
                        timer_load_s = 1'b1;
                        mod_s        = '0;
                        ph_s         = '0;
                        ph_acc_s     = base_r;
                        addr_acc_s   = base_r;
                        state_s      = ST_ADDR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_WAIT_TICK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, index accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            mod_r        <= '0;
            ph_r         <= '0;
            ph_acc_r     <= '0;
            addr_acc_r   <= '0;
            base_r       <= '0;
            drain_cnt_r  <= 2'd0;
            shoot_cnt_r  <= '0;
            start_tx_r   <= '0;
            data_r       <= '0;
            shoot_r      <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            mod_r        <= mod_s;
            ph_r         <= ph_s;
            ph_acc_r     <= ph_acc_s;
            addr_acc_r   <= addr_acc_s;
            base_r       <= base_s;
            drain_cnt_r  <= drain_cnt_s;
            shoot_cnt_r  <= shoot_cnt_s;
            start_tx_r   <= start_tx_s;
            if (capture_s) begin
                data_r[mod_r] <= ram_data;
            end
            shoot_r      <= (state_s == ST_SHOOT);
            frame_done_r <= (state_s == ST_SHOOT) && (shoot_cnt_s == SHOOT_LAST);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign ram_addr   = 16'(addr_acc_r);
    assign base_index = 16'(base_r);
    assign start_tx   = start_tx_r;
    assign data_to_tx = data_r;
    assign shoot      = shoot_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_sin_frame_dispatcher.sv
// Bench for sin_frame_dispatcher: dut0 runs default parameters, dut1 uses
// MODULE_OFFSET=10 and STEP_TICKS=20. Expected strobes (module, byte) are
// queued per frame and popped as start_tx pulses appear.
module tb_sin_frame_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0, en1;
    logic [15:0] ram_addr0, ram_addr1;
    logic [7:0]  ram_data0, ram_data1;
    logic [8:0]  start_tx0, start_tx1;
    logic [71:0] data0, data1;
    logic [8:0]  tx_busy0, tx_busy1;
    logic [8:0]  force0;
    logic        shoot0, shoot1, frame_done0, frame_done1, busy0, busy1;
    logic [15:0] base_index0, base_index1;

    int n_checks = 0;
    int n_pass   = 0;
    int q0[$];
    int q1[$];
    int strobes0 = 0, strobes1 = 0;
    int shoot_cyc0 = 0, fd0 = 0, fd1 = 0;
    int cyc = 0, last_fd_cyc1 = 0;
    int cap174 = 0;
    int bc0[9];
    int bc1[9];

    always #5 clk = ~clk;

    sin_frame_dispatcher dut0 (
        .clk(clk), .reset(rst_n), .enable(en0), .ram_addr(ram_addr0),
        .ram_data(ram_data0), .start_tx(start_tx0), .data_to_tx(data0),
        .tx_busy(tx_busy0), .shoot(shoot0), .frame_done(frame_done0),
        .base_index(base_index0), .busy(busy0)
    );

    sin_frame_dispatcher #(.MODULE_OFFSET(10), .STEP_TICKS(20)) dut1 (
        .clk(clk), .reset(rst_n), .enable(en1), .ram_addr(ram_addr1),
        .ram_data(ram_data1), .start_tx(start_tx1), .data_to_tx(data1),
        .tx_busy(tx_busy1), .shoot(shoot1), .frame_done(frame_done1),
        .base_index(base_index1), .busy(busy1)
    );

    // Sine table stand-in: table[k] = k, one-cycle read latency.
    always @(posedge clk) begin
        ram_data0 <= 8'(ram_addr0);
        ram_data1 <= 8'(ram_addr1);
    end

    // UART model: busy for 10 cycles after each start strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 9; i++) begin
            if (start_tx0[i]) bc0[i] <= 10;
            else if (bc0[i] != 0) bc0[i] <= bc0[i] - 1;
            if (start_tx1[i]) bc1[i] <= 10;
            else if (bc1[i] != 0) bc1[i] <= bc1[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            tx_busy0[i] = (bc0[i] != 0) || force0[i];
            tx_busy1[i] = (bc1[i] != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Queue one frame of (module, byte) expectations in phase-major order.
    task automatic push_frame(input int dut, input int base, input int moff);
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 9; i++) begin
                int d;
                d = (base + i * moff + j * 85) % 256;
                if (dut == 0) q0.push_back((i << 8) | d);
                else q1.push_back((i << 8) | d);
            end
        end
    endtask

    task automatic wait_frames(input int dut, input int n, input int budget, input string tag);
        int k = 0;
        while (((dut == 0) ? fd0 : fd1) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, (((dut == 0) ? fd0 : fd1) >= n), 1);
    endtask

    task automatic wait_strobes(input int dut, input int n, input int budget, input string tag);
        int k = 0;
        while (((dut == 0) ? strobes0 : strobes1) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, (((dut == 0) ? strobes0 : strobes1) >= n), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        en0    = 1'b0;
        force0 = 9'd0;
        repeat (2) @(negedge clk);
        q0.delete();
        strobes0   = 0;
        shoot_cyc0 = 0;
        fd0        = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard side: pop and compare on every strobe, count shoot activity.
    always @(negedge clk) begin : monitor
        int idx;
        int e;
        if (start_tx0 != 9'd0) begin
            chk("onehot0", $countones(start_tx0), 1);
            idx = 0;
            for (int b = 0; b < 9; b++) if (start_tx0[b]) idx = b;
            chk("strobe_expected0", (q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("module0", idx, e >> 8);
                chk("data0", data0[idx*8 +: 8], e & 255);
            end
            strobes0++;
        end
        if (shoot0) shoot_cyc0++;
        if (frame_done0) fd0++;
        if (start_tx1 != 9'd0) begin
            chk("onehot1", $countones(start_tx1), 1);
            idx = 0;
            for (int b = 0; b < 9; b++) if (start_tx1[b]) idx = b;
            chk("strobe_expected1", (q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("module1", idx, e >> 8);
                chk("data1", data1[idx*8 +: 8], e & 255);
            end
            if (strobes1 == 27 * 250 + 19) cap174 = int'(data1[15:8]);
            if (strobes1 > 0 && (strobes1 % 27) == 0)
                chk("b2b_gap1", ((cyc - last_fd_cyc1) <= 8), 1);
            strobes1++;
        end
        if (frame_done1) begin
            chk("base_at_done1", base_index1, fd1);
            fd1++;
            last_fd_cyc1 = cyc;
        end
    end

    initial begin
        rst_n  = 1'b0;
        en0    = 1'b0;
        en1    = 1'b0;
        force0 = 9'd0;
        for (int i = 0; i < 9; i++) begin
            bc0[i] = 0;
            bc1[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ram_addr", ram_addr0, 0);
        chk("rst_start_tx", start_tx0, 0);
        chk("rst_data_to_tx", data0, 0);
        chk("rst_shoot", shoot0, 0);
        chk("rst_frame_done", frame_done0, 0);
        chk("rst_base_index", base_index0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_busy1", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full default frame from base 0.
        push_frame(0, 0, 0);
        en0 = 1'b1;
        wait_frames(0, 1, 3000, "frame0");
        repeat (2) @(negedge clk);
        chk("frame0_queue_left", q0.size(), 0);
        chk("frame0_strobes", strobes0, 27);
        chk("frame0_shoot_cycles", shoot_cyc0, 4);
        chk("frame0_frame_done", fd0, 1);
        chk("frame0_base_index", base_index0, 1);

        // tx_busy[4] stuck for 200 cycles stalls the walk at module 4.
        do_reset();
        force0[4] = 1'b1;
        push_frame(0, 0, 0);
        en0 = 1'b1;
        wait_strobes(0, 4, 500, "stall_pre");
        repeat (200) @(negedge clk);
        chk("stall_strobes", strobes0, 4);
        chk("stall_busy", busy0, 1);
        chk("stall_no_shoot", shoot_cyc0, 0);
        force0[4] = 1'b0;
        wait_frames(0, 1, 3000, "stall_frame");
        repeat (2) @(negedge clk);
        chk("stall_queue_left", q0.size(), 0);
        chk("stall_strobes_total", strobes0, 27);
        chk("stall_shoot_cycles", shoot_cyc0, 4);

        // Reset asserted during the second shoot cycle.
        do_reset();
        push_frame(0, 0, 0);
        en0 = 1'b1;
        begin
            int k = 0;
            while (!shoot0 && k < 3000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("shoot_seen", shoot0, 1);
        @(posedge clk);
        #1;
        chk("shoot_cycle2_high", shoot0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_shoot", shoot0, 0);
        chk("async_rst_start_tx", start_tx0, 0);
        chk("async_rst_base_index", base_index0, 0);
        chk("async_rst_busy", busy0, 0);
        @(negedge clk);
        q0.delete();
        strobes0   = 0;
        shoot_cyc0 = 0;
        fd0        = 0;
        @(negedge clk);
        push_frame(0, 0, 0);
        rst_n = 1'b1;
        wait_frames(0, 1, 3000, "post_reset_frame");
        repeat (2) @(negedge clk);
        chk("post_reset_queue_left", q0.size(), 0);
        chk("post_reset_strobes", strobes0, 27);
        chk("post_reset_base_index", base_index0, 1);
        do_reset();

        // dut1: back-to-back frames (STEP_TICKS shorter than a frame), then
        // enable dropped after the 5th strobe of the frame with base 250.
        for (int k = 0; k <= 250; k++) push_frame(1, k, 10);
        en1 = 1'b1;
        wait_strobes(1, 27 * 250 + 5, 40000, "b2b_run");
        en1 = 1'b0;
        wait_frames(1, 251, 3000, "drop_frame");
        begin
            int k = 0;
            while (busy1 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("drop_idle_busy", busy1, 0);
        chk("drop_queue_left", q1.size(), 0);
        chk("drop_strobes_total", strobes1, 27 * 251);
        chk("addr_base250_i1_j2", cap174, 174);
        chk("drop_base_index", base_index1, 251);
        repeat (100) @(negedge clk);
        chk("drop_no_more_strobes", strobes1, 27 * 251);
        chk("drop_still_idle", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
